raster_scan_generator: RTL and testbench

RASTER_SCAN_GENERATOR -- requirements
Module: raster_scan_generator

---
 rtl/raster_scan_generator.sv | 170 +++++++++++++++++
 tb/tb_raster_scan_generator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_scan_generator.sv
// Raster address generator: walks col/row over a 2^WIDTH_BITS x 2^HEIGHT_BITS image and
// delays per-pixel framing flags LATENCY cycles to line up with a ROM reader. Option: RASTER_SCAN_LOOP_EN.
module raster_scan_generator #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int LATENCY     = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   iStart,
    input  logic                   iHold,
`ifdef RASTER_SCAN_LOOP_EN
    input  logic                   iStop,
`endif
    output logic [WIDTH_BITS-1:0]  oCol,
    output logic [HEIGHT_BITS-1:0] oRow,
    output logic                   oValid,
    output logic                   oSof,
    output logic                   oEol,
    output logic                   oEof,
    output logic                   oBusy,
    output logic                   oDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
        logic eof;
    } token_t;

    localparam logic [WIDTH_BITS-1:0]  COL_MAX    = '1;
    localparam logic [HEIGHT_BITS-1:0] ROW_MAX    = '1;
    // DRAIN spans the pipeline flush, the oDone cycle and one more, so oBusy covers oDone.
    localparam int                     DRAIN_BITS = $clog2(LATENCY + 2);
    localparam logic [DRAIN_BITS-1:0]  DRAIN_LAST = DRAIN_BITS'(LATENCY + 1);

    state_t                  state;
    logic [WIDTH_BITS-1:0]   col;
    logic [HEIGHT_BITS-1:0]  row;
    logic [DRAIN_BITS-1:0]   drain_cnt;
    token_t                  pipe [LATENCY];
    token_t                  pipe_out;
    token_t                  issue_tok;
    logic                    issue;
    logic                    col_last;
    logic                    row_last;
    logic                    frame_stop;

    assign issue    = (state == SCAN) && !iHold;
    assign col_last = (col == COL_MAX);
    assign row_last = (row == ROW_MAX);

`ifdef RASTER_SCAN_LOOP_EN
    logic stop_req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stop_req <= 1'b0;
        end else if (state == IDLE) begin
            stop_req <= 1'b0;
        end else if ((state == SCAN) && iStop) begin
            stop_req <= 1'b1;
        end
    end

    // A stop arriving on the last-pixel cycle still ends this frame.
    assign frame_stop = stop_req | iStop;
`else
    assign frame_stop = 1'b1;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        issue_tok = '0;
        if (issue) begin
            issue_tok.valid = 1'b1;
            issue_tok.sof   = (col == '0) && (row == '0);
            issue_tok.eol   = col_last;
            issue_tok.eof   = col_last && row_last;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this delay line holds control flags, so it is reset like any other register;
            // a data-only memory would be left unreset.
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= issue_tok;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign pipe_out = pipe[LATENCY-1];
    assign oValid   = pipe_out.valid;
    assign oSof     = pipe_out.sof;
    assign oEol     = pipe_out.eol;
    assign oEof     = pipe_out.eof;
    assign oCol     = col;
    assign oRow     = row;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            oDone <= pipe_out.valid & pipe_out.eof;
            case (state)
                IDLE: begin
                    col <= '0;
                    row <= '0;
                    if (iStart) begin
                        state <= SCAN;
                        oBusy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!iHold) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                row <= '0;
                                if (frame_stop) begin
                                    state     <= DRAIN;
                                    drain_cnt <= '0;
                                end
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    col <= '0;
                    row <= '0;
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_scan_generator.sv
// Self-checking bench for raster_scan_generator (4x4 image, LATENCY 2): directed frames
// with literal timing checks plus randomized start/hold/stop against a frame-level model.
module tb_raster_scan_generator;

    localparam int WB = 2;
    localparam int HB = 2;
    localparam int L  = 2;
    localparam int W  = 1 << WB;
    localparam int H  = 1 << HB;
    localparam int N  = W * H;
`ifdef RASTER_SCAN_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          iStart  = 1'b0;
    logic          iHold   = 1'b0;
`ifdef RASTER_SCAN_LOOP_EN
    logic          iStop   = 1'b0;
`endif
    logic [WB-1:0] oCol;
    logic [HB-1:0] oRow;
    logic          oValid, oSof, oEol, oEof, oBusy, oDone;

    raster_scan_generator #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB),
        .LATENCY    (L)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .iStart (iStart),
        .iHold  (iHold),
`ifdef RASTER_SCAN_LOOP_EN
        .iStop  (iStop),
`endif
        .oCol   (oCol),
        .oRow   (oRow),
        .oValid (oValid),
        .oSof   (oSof),
        .oEol   (oEol),
        .oEof   (oEof),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame-level model: pixel index, busy window and a per-cycle schedule of expected outputs.
    bit       m_busy, m_scan, m_stop;
    int       m_pix, m_idle_at;
    logic [3:0] tq [0:1023];
    bit         dq [0:1023];

    // Observations for the literal timing checks.
    int          v_cnt, v_first, v_last, sof_cyc, eof_cyc, done_cnt, eol_cnt, busy_low;
    bit          busy_seen;
    logic [63:0] v_mask, done_mask, eol_mask;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) begin
            tq[i] = '0;
            dq[i] = 1'b0;
        end
        m_busy = 0; m_scan = 0; m_stop = 0; m_pix = 0; m_idle_at = 0;
    endtask

    task automatic obs_clear();
        v_cnt = 0; v_first = -1; v_last = -1; sof_cyc = -1; eof_cyc = -1;
        done_cnt = 0; eol_cnt = 0; busy_low = -1; busy_seen = 0;
        v_mask = '0; done_mask = '0; eol_mask = '0;
    endtask

    task automatic compare();
        logic [3:0] et;
        et = tq[cyc];
        check("valid", int'(oValid), int'(et[3]));
        check("sof",   int'(oSof),   int'(et[2]));
        check("eol",   int'(oEol),   int'(et[1]));
        check("eof",   int'(oEof),   int'(et[0]));
        check("done",  int'(oDone),  int'(dq[cyc]));
        check("busy",  int'(oBusy),  int'(m_busy));
        check("col",   int'(oCol),   m_scan ? (m_pix % W) : 0);
        check("row",   int'(oRow),   m_scan ? (m_pix / W) : 0);
        if (oValid) begin
            v_cnt++;
            if (v_first < 0) v_first = cyc;
            v_last = cyc;
        end
        if (oSof && sof_cyc < 0) sof_cyc = cyc;
        if (oEof) eof_cyc = cyc;
        if (oEol) eol_cnt++;
        if (oDone) done_cnt++;
        if (cyc < 64) begin
            v_mask[cyc]    = oValid;
            done_mask[cyc] = oDone;
            eol_mask[cyc]  = oEol;
        end
        if (oBusy) busy_seen = 1;
        else if (busy_seen && busy_low < 0) busy_low = cyc;
    endtask

    task automatic model_advance(input bit st, input bit hd, input bit sp);
        if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_scan = 1; m_pix = 0;
            end
        end else if (m_scan) begin
            if (LOOP && sp) m_stop = 1;
            if (!hd) begin
                tq[cyc+L] = {1'b1, m_pix == 0, (m_pix % W) == W - 1, m_pix == N - 1};
                if (m_pix == N - 1) dq[cyc+L+1] = 1'b1;
                m_pix++;
                if (m_pix == N) begin
                    m_pix = 0;
                    if (!LOOP || m_stop) begin
                        m_scan    = 0;
                        m_idle_at = cyc + L + 3;
                    end
                end
            end
        end else if (cyc + 1 >= m_idle_at) begin
            m_busy = 0;
            m_stop = 0;
        end
    endtask

    task automatic run_cycle(input bit st, input bit hd, input bit sp);
        @(posedge clock);
        #1;
        iStart = st;
        iHold  = hd;
`ifdef RASTER_SCAN_LOOP_EN
        iStop  = sp;
`endif
        @(negedge clock);
        compare();
        model_advance(st, hd, sp);
        cyc++;
    endtask

    task automatic run_frame(input int ncyc, input int hold_lo, input int hold_hi,
                             input int restart_at, input int stop_at);
        model_clear();
        obs_clear();
        cyc = 0;
        for (int c = 0; c < ncyc; c++) begin
            run_cycle((c == 0) || (c == restart_at), (c >= hold_lo) && (c <= hold_hi), c == stop_at);
        end
    endtask

    initial begin
        model_clear();
        obs_clear();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst0_valid", int'(oValid), 0);
        check("rst0_busy",  int'(oBusy),  0);
        check("rst0_done",  int'(oDone),  0);
        check("rst0_col",   int'(oCol),   0);
        check("rst0_row",   int'(oRow),   0);
        check("rst0_flags", int'({oSof, oEol, oEof}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) run_cycle(0, 0, 0);

        // Basic frame
        run_frame(25, -1, -1, -1, -1);
        check("basic_vcnt",    v_cnt,   16);
        check("basic_vfirst",  v_first, 3);
        check("basic_vlast",   v_last,  18);
        check("basic_sof",     sof_cyc, 3);
        check("basic_eolcnt",  eol_cnt, 4);
        check("basic_eol6",    int'(eol_mask[6]),  1);
        check("basic_eol10",   int'(eol_mask[10]), 1);
        check("basic_eol14",   int'(eol_mask[14]), 1);
        check("basic_eol18",   int'(eol_mask[18]), 1);
        check("basic_eof",     eof_cyc, 18);
        check("basic_done19",  int'(done_mask[19]), 1);
        check("basic_donecnt", done_cnt, 1);
        check("basic_busylow", busy_low, 21);

        // Stall during cycles 5-6
        run_frame(26, 5, 6, -1, -1);
        check("stall_v7",   int'(v_mask[7]), 0);
        check("stall_v8",   int'(v_mask[8]), 0);
        check("stall_vcnt", v_cnt, 16);
        check("stall_eof",  eof_cyc, 20);

        // Start re-pulsed while busy
        run_frame(25, -1, -1, 10, -1);
        check("restart_vcnt",    v_cnt, 16);
        check("restart_donecnt", done_cnt, 1);

        // Mid-frame reset at cycle 8
        model_clear();
        obs_clear();
        cyc = 0;
        for (int c = 0; c < 8; c++) run_cycle(c == 0, 0, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", int'(oValid), 0);
        check("midrst_busy",  int'(oBusy),  0);
        check("midrst_done",  int'(oDone),  0);
        check("midrst_col",   int'(oCol),   0);
        check("midrst_row",   int'(oRow),   0);
        check("midrst_flags", int'({oSof, oEol, oEof}), 0);
        model_clear();
        obs_clear();
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 9;
        for (int c = 0; c < 12; c++) run_cycle(0, 0, 0);
        check("midrst_nodone",  done_cnt, 0);
        check("midrst_novalid", v_cnt, 0);
        run_frame(25, -1, -1, -1, -1);
        check("after_rst_vcnt", v_cnt, 16);
        check("after_rst_sof",  sof_cyc, 3);
        check("after_rst_done", int'(done_mask[19]), 1);

`ifdef RASTER_SCAN_LOOP_EN
        // Loop mode with a stop pulse at cycle 20
        run_frame(45, -1, -1, -1, 20);
        check("loop_vcnt",    v_cnt, 32);
        check("loop_vfirst",  v_first, 3);
        check("loop_vlast",   v_last, 34);
        check("loop_done19",  int'(done_mask[19]), 1);
        check("loop_done35",  int'(done_mask[35]), 1);
        check("loop_donecnt", done_cnt, 2);
        check("loop_busylow", busy_low, 37);
`endif

        // Randomized start/hold/stop, then a quiet tail that lets any frame finish
        model_clear();
        obs_clear();
        cyc = 0;
        for (int c = 0; c < 600; c++) begin
            run_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
        end
        for (int c = 0; c < 60; c++) run_cycle(0, 0, 1);
        check("rand_idle", int'(oBusy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
